// File: rtl/ex_pkg.sv
// ex_pkg -- shared definitions for the EX pipeline stage.
//
// Holds the ALU command codes, the bit layout of the ID/EX and EX/MEM
// pipeline buses, and the encoding of the multiply FSM states.
//
// The control fields (mem_we, mem_wdata, wb_en, wb_dest, wb_sel) occupy
// the low CTRL_W bits of both buses with an identical layout. EX can
// therefore carry them across as one slice.

package ex_pkg;

   localparam int DATA_W   = 16;
   localparam int CMD_W    = 4;
   localparam int SHAMT_W  = 4;
   localparam int CTRL_W   = 22;
   localparam int ID_EX_W  = 58;
   localparam int EX_MEM_W = 38;

   // id_ex_bus field offsets
   localparam int CMD_LSB  = 54;
   localparam int SRC1_LSB = 38;
   localparam int SRC2_LSB = 22;

   // Shared control-field offsets (same position in both buses)
   localparam int MEM_WE_BIT    = 21;
   localparam int MEM_WDATA_LSB = 5;
   localparam int WB_EN_BIT     = 4;
   localparam int WB_DEST_LSB   = 1;
   localparam int WB_DEST_W     = 3;
   localparam int WB_SEL_BIT    = 0;

   // ex_mem_bus field offsets
   localparam int RESULT_LSB = 22;

   // Command codes; 11-15 are reserved
   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_AND = 4'd3;
   localparam logic [CMD_W-1:0] CMD_OR  = 4'd4;
   localparam logic [CMD_W-1:0] CMD_NOR = 4'd5;
   localparam logic [CMD_W-1:0] CMD_XOR = 4'd6;
   localparam logic [CMD_W-1:0] CMD_SLL = 4'd7;
   localparam logic [CMD_W-1:0] CMD_SRL = 4'd8;
   localparam logic [CMD_W-1:0] CMD_SRA = 4'd9;
   localparam logic [CMD_W-1:0] CMD_MUL = 4'd10;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } state_e;

endpackage

// File: rtl/ex_alu.sv
// ex_alu -- combinational single-cycle ALU of the EX stage.
//
// Ports:
//   cmd    [3:0]  : operation code (see ex_pkg)
//   src1   [15:0] : first operand
//   src2   [15:0] : second operand; src2[3:0] is the shift amount
//   result [15:0] : 16-bit result, modulo 2^16
//
// NOP, MUL and the reserved codes produce 0. MUL is handled by the
// iterative multiplier in ex_stage, not here.

module ex_alu
   import ex_pkg::*;
(
   input  logic [CMD_W-1:0]  cmd,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic [DATA_W-1:0] result
);

   logic [SHAMT_W-1:0] shamt;

   assign shamt = src2[SHAMT_W-1:0];

   // NOTE: assign a default before the case so every path drives result;
   // a missing assignment in combinational logic infers a latch.
   always_comb begin
      result = '0;
      unique case (cmd)
         CMD_ADD: result = src1 + src2;
         CMD_SUB: result = src1 - src2;
         CMD_AND: result = src1 & src2;
         CMD_OR:  result = src1 | src2;
         CMD_NOR: result = ~(src1 | src2);
         CMD_XOR: result = src1 ^ src2;
         CMD_SLL: result = src1 << shamt;
         CMD_SRL: result = src1 >> shamt;
         CMD_SRA: result = DATA_W'($signed(src1) >>> shamt);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// ex_stage -- EX pipeline stage: single-cycle ALU plus an optional
// iterative 16x16 shift-add multiplier. The stage ends in the EX/MEM
// pipeline register.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-high reset
//   id_ex_bus  : [57:54] cmd, [53:38] src1, [37:22] src2, [21:0] control
//   mem_stall  : MEM cannot accept; all state holds
//   ex_busy    : upstream must hold id_ex_bus stable while high
//   ex_mem_bus : [37:22] alu_result, [21:0] control (registered)
//
// Configuration:
//   EX_MUL_EN defined   -> cmd 10 runs a 16-iteration multiply FSM.
//   EX_MUL_EN undefined -> cmd 10 is reserved, ex_busy == mem_stall.

module ex_stage
   import ex_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [ID_EX_W-1:0]  id_ex_bus,
   input  logic                mem_stall,
   output logic                ex_busy,
   output logic [EX_MEM_W-1:0] ex_mem_bus
);

   logic [CMD_W-1:0]  cmd;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] alu_result;

   assign cmd  = id_ex_bus[CMD_LSB  +: CMD_W];
   assign src1 = id_ex_bus[SRC1_LSB +: DATA_W];
   assign src2 = id_ex_bus[SRC2_LSB +: DATA_W];
   assign ctrl = id_ex_bus[CTRL_W-1:0];

   ex_alu u_alu (
      .cmd    (cmd),
      .src1   (src1),
      .src2   (src2),
      .result (alu_result)
   );

`ifdef EX_MUL_EN

   state_e            state,    state_next;
   logic [3:0]        cnt,      cnt_next;
   logic [DATA_W-1:0] mcand,    mcand_next;
   logic [DATA_W-1:0] mplier,   mplier_next;
   logic [DATA_W-1:0] acc,      acc_next;
   logic [CTRL_W-1:0] ctrl_cap, ctrl_cap_next;
   logic [EX_MEM_W-1:0] bus_next;
   logic [DATA_W-1:0] partial;

   // One shift-add step. Only the low 16 product bits are kept, so
   // mcand shifts left and the bits that fall off never matter.
   assign partial = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      mcand_next    = mcand;
      mplier_next   = mplier;
      acc_next      = acc;
      ctrl_cap_next = ctrl_cap;
      bus_next      = ex_mem_bus;

      if (!mem_stall) begin
         unique case (state)
            IDLE: begin
               if (cmd == CMD_MUL) begin
                  mcand_next    = src1;
                  mplier_next   = src2;
                  acc_next      = '0;
                  ctrl_cap_next = ctrl;
                  cnt_next      = '0;
                  bus_next      = '0;
                  state_next    = MUL_RUN;
               end else begin
                  bus_next = {alu_result, ctrl};
               end
            end
            MUL_RUN: begin
               acc_next    = partial;
               mcand_next  = mcand << 1;
               mplier_next = mplier >> 1;
               cnt_next    = cnt + 4'd1;
               bus_next    = '0;
               // partial already includes the 16th iteration here
               if (cnt == 4'd15) begin
                  bus_next   = {partial, ctrl_cap};
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         acc        <= '0;
         ctrl_cap   <= '0;
         ex_mem_bus <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         mcand      <= mcand_next;
         mplier     <= mplier_next;
         acc        <= acc_next;
         ctrl_cap   <= ctrl_cap_next;
         ex_mem_bus <= bus_next;
      end
   end

   assign ex_busy = (state == MUL_RUN) || mem_stall;

`else

   always_ff @(posedge clock) begin
      if (reset) begin
         ex_mem_bus <= '0;
      end else if (!mem_stall) begin
         ex_mem_bus <= {alu_result, ctrl};
      end
   end

   assign ex_busy = mem_stall;

`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed self-checking bench for ex_stage.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the next edge.
// MUL scenarios are compiled when EX_MUL_EN is defined.

module tb_ex_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [57:0] id_ex_bus;
   logic        mem_stall;
   logic        ex_busy;
   logic [37:0] ex_mem_bus;

   int n_cmp = 0;
   int n_bad = 0;

   ex_stage dut (
      .clock      (clock),
      .reset      (reset),
      .id_ex_bus  (id_ex_bus),
      .mem_stall  (mem_stall),
      .ex_busy    (ex_busy),
      .ex_mem_bus (ex_mem_bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  cmd;
      logic [15:0] s1;
      logic [15:0] s2;
      logic [15:0] res;
      string       name;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [21:0] mk_ctrl(input logic we, input logic [15:0] wd,
                                           input logic en, input logic [2:0] dest,
                                           input logic sel);
      return {we, wd, en, dest, sel};
   endfunction

   function automatic logic [57:0] mk_bus(input logic [3:0] cmd, input logic [15:0] s1,
                                          input logic [15:0] s2, input logic [21:0] c);
      return {cmd, s1, s2, c};
   endfunction

   logic [21:0] c;

   initial begin
      reset     = 1'b1;
      mem_stall = 1'b0;
      id_ex_bus = '0;
      step();
      step();
      check("reset_bus", ex_mem_bus, 38'h0);
      check("reset_busy", ex_busy, 1'b0);
      reset = 1'b0;

      // ADD overflow into bit 15, control fields passed through
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd5, 1'b0);
      id_ex_bus = mk_bus(4'd1, 16'h7FFF, 16'h0001, c);
      check("add_busy_before", ex_busy, 1'b0);
      step();
      check("add_result", ex_mem_bus[37:22], 16'h8000);
      check("add_wb_en", ex_mem_bus[4], 1'b1);
      check("add_wb_dest", ex_mem_bus[3:1], 3'd5);
      check("add_busy_after", ex_busy, 1'b0);

      vecs[0]  = '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, "sub"};
      vecs[1]  = '{4'd3,  16'hF0F0, 16'h3C3C, 16'h3030, "and"};
      vecs[2]  = '{4'd4,  16'hF0F0, 16'h0F01, 16'hFFF1, "or"};
      vecs[3]  = '{4'd5,  16'hF0F0, 16'h0F00, 16'h000F, "nor"};
      vecs[4]  = '{4'd6,  16'hAAAA, 16'hFFFF, 16'h5555, "xor"};
      vecs[5]  = '{4'd7,  16'h0001, 16'h0013, 16'h0008, "sll"};
      vecs[6]  = '{4'd8,  16'h8000, 16'h0004, 16'h0800, "srl"};
      vecs[7]  = '{4'd9,  16'h8000, 16'h0004, 16'hF800, "sra"};
      vecs[8]  = '{4'd13, 16'h1234, 16'h5678, 16'h0000, "rsv13"};
      vecs[9]  = '{4'd0,  16'hFFFF, 16'hFFFF, 16'h0000, "nop"};
      vecs[10] = '{4'd15, 16'h0001, 16'h0001, 16'h0000, "rsv15"};

      for (int i = 0; i < 11; i++) begin
         c = mk_ctrl(i[0], 16'hBEEF ^ 16'(i), ~i[0], 3'(i), i[1]);
         id_ex_bus = mk_bus(vecs[i].cmd, vecs[i].s1, vecs[i].s2, c);
         step();
         check($sformatf("%s_bus", vecs[i].name), ex_mem_bus, {vecs[i].res, c});
         check($sformatf("%s_busy", vecs[i].name), ex_busy, 1'b0);
      end

      // mem_stall freezes the output register and raises ex_busy
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd2, 1'b0);
      id_ex_bus = mk_bus(4'd1, 16'h0002, 16'h0003, c);
      step();
      check("pre_stall", ex_mem_bus, {16'h0005, c});
      mem_stall = 1'b1;
      id_ex_bus = mk_bus(4'd6, 16'h00FF, 16'h0F0F, mk_ctrl(1'b1, 16'h1111, 1'b0, 3'd7, 1'b1));
      check("stall_busy", ex_busy, 1'b1);
      step();
      check("stall_hold1", ex_mem_bus, {16'h0005, c});
      step();
      check("stall_hold2", ex_mem_bus, {16'h0005, c});
      mem_stall = 1'b0;
      check("unstall_busy", ex_busy, 1'b0);
      step();
      check("unstall_bus", ex_mem_bus, {16'h0FF0, mk_ctrl(1'b1, 16'h1111, 1'b0, 3'd7, 1'b1)});

      // reset wins over mem_stall
      mem_stall = 1'b1;
      reset     = 1'b1;
      step();
      check("rst_over_stall_bus", ex_mem_bus, 38'h0);
      check("rst_over_stall_busy", ex_busy, 1'b1);
      reset     = 1'b0;
      mem_stall = 1'b0;
      check("rst_release_busy", ex_busy, 1'b0);

`ifdef EX_MUL_EN
      // MUL 0x0123 x 0x0045 = 0x4E6F; 16 busy cycles of bubbles
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd3, 1'b1);
      id_ex_bus = mk_bus(4'd10, 16'h0123, 16'h0045, c);
      step();
      id_ex_bus = mk_bus(4'd1, 16'h1111, 16'h2222, mk_ctrl(1'b1, 16'hFFFF, 1'b1, 3'd7, 1'b1));
      check("mul1_accept_busy", ex_busy, 1'b1);
      check("mul1_accept_bus", ex_mem_bus, 38'h0);
      for (int i = 1; i < 16; i++) begin
         step();
         check($sformatf("mul1_busy_%0d", i), ex_busy, 1'b1);
         check($sformatf("mul1_bubble_%0d", i), ex_mem_bus, 38'h0);
      end
      step();
      check("mul1_result", ex_mem_bus, {16'h4E6F, c});
      check("mul1_done_busy", ex_busy, 1'b0);

      // back-to-back: next MUL accepted at the first IDLE edge
      c = mk_ctrl(1'b1, 16'hA5A5, 1'b0, 3'd1, 1'b0);
      id_ex_bus = mk_bus(4'd10, 16'hFFFF, 16'hFFFF, c);
      step();
      id_ex_bus = '0;
      check("mul2_accept_busy", ex_busy, 1'b1);
      for (int i = 1; i < 16; i++) step();
      check("mul2_bubble_15", ex_mem_bus, 38'h0);
      step();
      check("mul2_result", ex_mem_bus, {16'h0001, c});

      // stall 3 cycles starting 5 cycles after acceptance -> result after edge 19
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd4, 1'b0);
      id_ex_bus = mk_bus(4'd10, 16'h0123, 16'h0045, c);
      step();
      id_ex_bus = '0;
      for (int i = 1; i <= 5; i++) step();
      mem_stall = 1'b1;
      for (int i = 6; i <= 8; i++) begin
         step();
         check($sformatf("mul3_frozen_%0d", i), ex_mem_bus, 38'h0);
      end
      mem_stall = 1'b0;
      for (int i = 9; i <= 18; i++) step();
      check("mul3_edge18", ex_mem_bus, 38'h0);
      check("mul3_edge18_busy", ex_busy, 1'b1);
      step();
      check("mul3_result", ex_mem_bus, {16'h4E6F, c});

      // reset 8 cycles into a MUL aborts it
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd6, 1'b0);
      id_ex_bus = mk_bus(4'd10, 16'h0123, 16'h0045, c);
      step();
      id_ex_bus = '0;
      for (int i = 1; i < 8; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mul_abort_bus", ex_mem_bus, 38'h0);
      check("mul_abort_busy", ex_busy, 1'b0);
      c = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd2, 1'b0);
      id_ex_bus = mk_bus(4'd1, 16'h0002, 16'h0003, c);
      step();
      check("post_abort_add", ex_mem_bus, {16'h0005, c});
      id_ex_bus = '0;
      for (int i = 0; i < 18; i++) begin
         step();
         check($sformatf("no_product_%0d", i), ex_mem_bus, 38'h0);
      end
`else
      // cmd 10 is reserved without the multiplier
      c = mk_ctrl(1'b1, 16'h00AA, 1'b1, 3'd3, 1'b1);
      id_ex_bus = mk_bus(4'd10, 16'h0003, 16'h0004, c);
      check("mul_off_busy_before", ex_busy, 1'b0);
      step();
      check("mul_off_bus", ex_mem_bus, {16'h0000, c});
      id_ex_bus = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("mul_off_busy_%0d", i), ex_busy, 1'b0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: rising-edge clock; reset is `reset`, synchronous, active-high.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset; clock is `clock`.
REQ-003 SHALL have port `id_ex_bus`, input, 58 bits: the ID/EX register contents, laid out as follows.
- [57:54] cmd
- [53:38] src1
- [37:22] src2
- [21] mem_we
- [20:5] mem_wdata
- [4] wb_en
- [3:1] wb_dest
- [0] wb_sel
REQ-004 SHALL have port `mem_stall`, input, 1 bit: the downstream MEM stage cannot accept; hold all state.
REQ-005 SHALL have port `ex_busy`, output, 1 bit: upstream SHALL hold `id_ex_bus` stable while this is high.
REQ-006 SHALL have port `ex_mem_bus`, output, 38 bits: the registered EX/MEM bundle, laid out as follows.
- [37:22] alu_result
- [21] mem_we
- [20:5] mem_wdata
- [4] wb_en
- [3:1] wb_dest
- [0] wb_sel

Function
REQ-007 SHALL decode cmd as follows: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11-15 reserved.
REQ-008 Arithmetic is 16-bit modulo 2^16 with no flags; shift amount is src2[3:0]; SRA replicates src1[15].
REQ-009 NOP and reserved cmds SHALL produce alu_result=0x0000 and pass the control fields through unchanged.
REQ-010 Single-cycle ops (cmd 0-9, 11-15) SHALL have latency 1: `id_ex_bus` is sampled at edge N and the result plus control fields are visible in `ex_mem_bus` after edge N.
REQ-011 The FSM SHALL have two states, IDLE and MUL_RUN, plus a 4-bit iteration counter.
REQ-012 In IDLE with cmd=10, the block SHALL do the following at that edge:
- capture src1, src2 and all control fields;
- clear the counter;
- load a zero bubble into `ex_mem_bus`;
- go to MUL_RUN.
REQ-013 In MUL_RUN, the block SHALL do the following:
- one shift-add iteration per edge;
- counter increments;
- `ex_mem_bus` loads a zero bubble each edge;
- `id_ex_bus` is ignored.
REQ-014 On the MUL_RUN edge where counter==15, the block SHALL do the following:
- load the low 16 bits of the product, with the captured control fields, into `ex_mem_bus`;
- return to IDLE.
- Net effect: the result is visible after the 16th edge following acceptance.
REQ-015 `ex_busy` SHALL equal (state==MUL_RUN) OR `mem_stall`; it is high for exactly 16 cycles after MUL acceptance when `mem_stall` stays low.
REQ-016 While `mem_stall`=1, `ex_mem_bus`, the state, the counter and the multiplier registers SHALL hold; no `id_ex_bus` sample is taken.
REQ-017 A MUL immediately following a MUL SHALL be accepted at the first IDLE edge after the previous MUL completes.

Reset
REQ-018 When `reset`=1 at an edge, the block SHALL:
- zero `ex_mem_bus`;
- set the state to IDLE;
- zero the counter and the multiplier registers;
- deassert `ex_busy` (unless `mem_stall` is high).
REQ-019 Reset SHALL take priority over `mem_stall` and over an in-flight MUL; the aborted MUL produces no result.

Configuration
REQ-020 With macro `EX_MUL_EN` defined, the MUL FSM and multiplier SHALL be compiled in as specified above.
REQ-021 Without `EX_MUL_EN`:
- cmd 10 SHALL behave as reserved (single-cycle, result 0x0000);
- the FSM and counter SHALL be absent;
- `ex_busy` SHALL equal `mem_stall`.

Structure
REQ-022 Shared package `ex_pkg` SHALL hold:
- cmd code constants;
- `id_ex_bus` and `ex_mem_bus` field offsets and widths;
- FSM state encoding.
REQ-023 The combinational single-cycle ALU SHALL be a sub-module named `ex_alu`; the FSM, multiplier, output register and hold logic reside in `ex_stage`.

Verification
REQ-024 ADD: src1=0x7FFF, src2=0x0001, wb_en=1, wb_dest=5 -> after 1 edge: alu_result=0x8000, wb_en=1, wb_dest=5, `ex_busy`=0 throughout.
REQ-025 Shifts:
- SRA src1=0x8000, src2=0x0004 -> 0xF800.
- SLL src1=0x0001, src2=0x0013 -> 0x0008.
- Reserved cmd 13 -> 0x0000 with control fields passed through.
REQ-026 MUL 0x0123 x 0x0045, with `EX_MUL_EN` defined:
- `ex_busy` high 16 cycles;
- bubbles on `ex_mem_bus`;
- after the 16th edge, alu_result=0x4E6F.
- Repeating with 0xFFFF x 0xFFFF -> 0x0001.
REQ-027 MUL with `mem_stall`=1 for 3 cycles starting 5 cycles after acceptance -> `ex_mem_bus` frozen during the stall; result 0x4E6F appears after the 19th edge.
REQ-028 Reset asserted 8 cycles into a MUL:
- `ex_mem_bus`=0 and `ex_busy`=0 after that edge;
- no product ever appears;
- a following ADD 2+3 -> 0x0005 after 1 edge.
REQ-029 Without `EX_MUL_EN`: cmd 10 with src1=3, src2=4 -> alu_result=0x0000 after 1 edge, `ex_busy` never high.
